psg_spi_writer: RTL and testbench

Upstream front-end for the SN76489-compatible PSG core. It receives register bytes over a 3-wire SPI slave link (mode 0, MSB first) and buffers them in a small FIFO. It replays each byte to the PSG write port as a single-cycle active-low write strobe, with a guaranteed minimum gap between strobes. It lets a host stream PSG commands at SPI speed without controlling the PSG's level-sensitive `/WE` timing.

---
 rtl/psg_pkg.sv | 8 +
 rtl/psg_sync_fifo.sv | 64 ++++++
 rtl/psg_spi_writer.sv | 137 +++++++++++++
 tb/tb_psg_spi_writer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// Shared constants and types for the PSG SPI write front-end.
package psg_pkg;
    localparam int PSG_DATA_BITS = 8;
    localparam int PSG_WRITE_GAP = 16;
    localparam int SYNC_STAGES   = 2;

    typedef logic [PSG_DATA_BITS-1:0] psg_byte_t;
endpackage

// File: rtl/psg_sync_fifo.sv
// Single-clock FIFO; a push while full is taken only when a pop frees a slot in the same cycle.
module psg_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             empty_next
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok  = push & (~full_q | pop);
        pop_ok   = pop & ~empty_q;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
        else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data   = mem_q[rd_ptr_q];
    assign full       = full_q;
    assign empty      = empty_q;
    assign empty_next = empty_d;
endmodule

// File: rtl/psg_spi_writer.sv
// SPI mode-0 byte receiver feeding a FIFO, replayed to the PSG as paced one-cycle /WE strobes.
module psg_spi_writer
    import psg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WRITE_GAP  = PSG_WRITE_GAP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_sck,
    input  logic                     spi_cs_n,
    input  logic                     spi_mosi,
    output logic [PSG_DATA_BITS-1:0] psg_data,
    output logic                     psg_we_n,
    output logic                     fifo_full,
    output logic                     overflow,
    output logic                     busy
);
    localparam int GAP_W = $clog2(WRITE_GAP);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_dly_q, cs_dly_q, mosi_dly_q;
    logic                   sck_rise;

    logic [2:0]  bit_cnt_q, bit_cnt_d;
    psg_byte_t   shift_q, shift_d;
    logic        push_q, push_d;
    psg_byte_t   push_data_q, push_data_d;

    logic [GAP_W-1:0] gap_q, gap_d;
    psg_byte_t        psg_data_q, psg_data_d;
    logic             we_n_q, we_n_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;

    logic             pop;
    psg_byte_t        fifo_head;
    logic             fifo_full_w, fifo_empty, fifo_empty_next;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        // cs and mosi are taken from their third flop so they line up with sck_dly_q.
        sck_rise    = sck_sync_q[SYNC_STAGES-1] & ~sck_dly_q;
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        if (cs_dly_q) begin
            bit_cnt_d = '0;
        end else if (sck_rise) begin
            shift_d   = {shift_q[PSG_DATA_BITS-2:0], mosi_dly_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                push_d      = 1'b1;
                push_data_d = shift_d;
            end
        end
    end

    always_comb begin
        pop        = ~fifo_empty & (gap_q == '0);
        psg_data_d = psg_data_q;
        we_n_d     = 1'b1;
        gap_d      = (gap_q == '0) ? gap_q : gap_q - GAP_W'(1);
        if (pop) begin
            psg_data_d = fifo_head;
            we_n_d     = 1'b0;
            gap_d      = GAP_W'(WRITE_GAP - 1);
        end
        overflow_d = overflow_q | (push_q & fifo_full_w & ~pop);
        busy_d     = ~fifo_empty_next | (gap_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_dly_q   <= 1'b0;
            cs_dly_q    <= 1'b1;
            mosi_dly_q  <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            gap_q       <= '0;
            psg_data_q  <= '0;
            we_n_q      <= 1'b1;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_dly_q   <= sck_sync_q[SYNC_STAGES-1];
            cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
            mosi_dly_q  <= mosi_sync_q[SYNC_STAGES-1];
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            gap_q       <= gap_d;
            psg_data_q  <= psg_data_d;
            we_n_q      <= we_n_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
        end
    end

    psg_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PSG_DATA_BITS)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_q),
        .push_data  (push_data_q),
        .pop        (pop),
        .pop_data   (fifo_head),
        .full       (fifo_full_w),
        .empty      (fifo_empty),
        .empty_next (fifo_empty_next)
    );

    assign psg_data  = psg_data_q;
    assign psg_we_n  = we_n_q;
    assign fifo_full = fifo_full_w;
    assign overflow  = overflow_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_psg_spi_writer.sv
// Scoreboard bench: SPI stimulus queues expected PSG writes; per-DUT monitors check each strobe.
module tb_psg_spi_writer;
    localparam int GAP_B = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n;
    logic sck, cs_n, mosi, sel_b;
    logic sck_a, cs_a, mosi_a, sck_b, cs_b, mosi_b;
    logic [7:0] psg_data_a, psg_data_b;
    logic we_n_a, we_n_b, full_a, full_b, ovf_a, ovf_b, busy_a, busy_b;

    assign sck_a  = sel_b ? 1'b0 : sck;
    assign cs_a   = sel_b ? 1'b1 : cs_n;
    assign mosi_a = sel_b ? 1'b0 : mosi;
    assign sck_b  = sel_b ? sck : 1'b0;
    assign cs_b   = sel_b ? cs_n : 1'b1;
    assign mosi_b = sel_b ? mosi : 1'b0;

    psg_spi_writer u_a (
        .clk(clk), .rst_n(rst_a_n), .spi_sck(sck_a), .spi_cs_n(cs_a), .spi_mosi(mosi_a),
        .psg_data(psg_data_a), .psg_we_n(we_n_a), .fifo_full(full_a), .overflow(ovf_a), .busy(busy_a)
    );

    // Gap large enough that no second pop happens while a 6-byte clk/4 burst arrives.
    psg_spi_writer #(.FIFO_DEPTH(4), .WRITE_GAP(GAP_B)) u_b (
        .clk(clk), .rst_n(rst_b_n), .spi_sck(sck_b), .spi_cs_n(cs_b), .spi_mosi(mosi_b),
        .psg_data(psg_data_b), .psg_we_n(we_n_b), .fifo_full(full_b), .overflow(ovf_b), .busy(busy_b)
    );

    typedef struct {
        logic [7:0] data;
        int         at_cyc;
        int         gap;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   cyc = 0;
    int   last_a = 0, last_b = 0;
    int   n_tests = 0, n_fail = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_a_n === 1'b1 && we_n_a === 1'b0) begin
            if (q_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected_strobe: got data 0x%0h, expected no strobe (cycle %0d)", psg_data_a, cyc);
            end else begin
                e_a = q_a.pop_front();
                check("a_data", psg_data_a, e_a.data);
                if (e_a.at_cyc >= 0) check("a_strobe_cycle", cyc, e_a.at_cyc);
                if (e_a.gap > 0) check("a_strobe_gap", cyc - last_a, e_a.gap);
            end
            last_a = cyc;
        end
    end

    always @(negedge clk) begin
        if (rst_b_n === 1'b1 && we_n_b === 1'b0) begin
            if (q_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_strobe: got data 0x%0h, expected no strobe (cycle %0d)", psg_data_b, cyc);
            end else begin
                e_b = q_b.pop_front();
                check("b_data", psg_data_b, e_b.data);
                if (e_b.at_cyc >= 0) check("b_strobe_cycle", cyc, e_b.at_cyc);
                if (e_b.gap > 0) check("b_strobe_gap", cyc - last_b, e_b.gap);
            end
            last_b = cyc;
        end
    end

    // mode: 0 = no write expected, 1 = write 5 cycles after the 8th rise, 2 = write GAP_B after the previous one
    task automatic spi_byte(input logic [7:0] b, input int nbits, input int half, input int mode);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            repeat (half) @(negedge clk);
            sck = 1'b1;
            if (i == 7 && mode != 0) begin
                e.data   = b;
                e.at_cyc = (mode == 1) ? cyc + 5 : -1;
                e.gap    = (mode == 2) ? GAP_B : 0;
                if (sel_b) q_b.push_back(e);
                else       q_a.push_back(e);
            end
            repeat (half) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (q_a.size() + q_b.size()), 0);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int n;
        sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; sel_b = 1'b0;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", psg_data_a, 8'h00);
        check("rst_we_n", we_n_a, 1'b1);
        check("rst_full", full_a, 1'b0);
        check("rst_overflow", ovf_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_b_busy", busy_b, 1'b0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_we_n", we_n_a, 1'b1);
        check("idle_busy", busy_a, 1'b0);

        // Single byte at sck = clk/8
        cs_start();
        spi_byte(8'h9F, 8, 4, 1);
        cs_end();
        wait_drain("single_drain", 200);
        check("single_hold_data", psg_data_a, 8'h9F);
        check("single_we_n_high", we_n_a, 1'b1);
        wait_until(last_a + 14);
        check("single_busy_during_gap", busy_a, 1'b1);
        wait_until(last_a + 16);
        check("single_busy_after_gap", busy_a, 1'b0);

        // Three bytes back-to-back in one frame
        cs_start();
        spi_byte(8'h80, 8, 4, 1);
        spi_byte(8'h3F, 8, 4, 1);
        spi_byte(8'h91, 8, 4, 1);
        cs_end();
        wait_drain("burst_drain", 300);
        check("burst_overflow", ovf_a, 1'b0);
        check("burst_hold_data", psg_data_a, 8'h91);

        // Partial byte discarded by cs_n rising
        cs_start();
        spi_byte(8'hA5, 5, 4, 0);
        cs_end();
        cs_start();
        spi_byte(8'hE4, 8, 4, 1);
        cs_end();
        wait_drain("partial_drain", 200);
        repeat (40) @(negedge clk);
        check("partial_hold_data", psg_data_a, 8'hE4);

        // Overflow on the slow-gap instance, sck = clk/4
        sel_b = 1'b1;
        cs_start();
        spi_byte(8'h11, 8, 2, 1);
        spi_byte(8'h22, 8, 2, 2);
        spi_byte(8'h33, 8, 2, 2);
        spi_byte(8'h44, 8, 2, 2);
        spi_byte(8'h55, 8, 2, 2);
        repeat (3) @(negedge clk);
        check("ovf_full_after_5", full_b, 1'b1);
        check("ovf_not_yet", ovf_b, 1'b0);
        spi_byte(8'h66, 8, 2, 0);
        repeat (3) @(negedge clk);
        check("ovf_set", ovf_b, 1'b1);
        check("ovf_still_full", full_b, 1'b1);
        cs_end();
        wait_drain("ovf_drain", 2000);
        repeat (300) @(negedge clk);
        check("ovf_sticky", ovf_b, 1'b1);
        check("ovf_empty_full", full_b, 1'b0);
        check("ovf_busy_idle", busy_b, 1'b0);
        check("ovf_last_data", psg_data_b, 8'h55);
        sel_b = 1'b0;
        repeat (4) @(negedge clk);

        // Reset asserted during the strobe cycle
        cs_start();
        spi_byte(8'hC3, 8, 4, 1);
        n = 0;
        while (we_n_a !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_strobe_seen", we_n_a, 1'b0);
        #2 rst_a_n = 1'b0;
        #1;
        check("rst_mid_we_n", we_n_a, 1'b1);
        check("rst_mid_data", psg_data_a, 8'h00);
        check("rst_mid_busy", busy_a, 1'b0);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_a_n = 1'b1;
        repeat (60) @(negedge clk);
        check("rst_mid_no_restrobe_data", psg_data_a, 8'h00);
        check("rst_mid_busy_after", busy_a, 1'b0);

        check("pending_expectations", (q_a.size() + q_b.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
